flag_unit: RTL and testbench

FLAG_UNIT -- requirements
Module: flagunit

---
 rtl/flag_unit.sv | 118 +++++++++++
 tb/tb_flag_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/flag_unit.sv
// flag_unit: condition-flag register with a pending-setter scoreboard.
// Computes {N,Z,V,C} for ADD/SUB/AND results and loads them on a flag-setting
// writeback. It also counts in-flight flag setters, so branches that depend on
// flags can stall until every outstanding setter has retired.
// Optional build macro FLAGBYPASS_EN: forwards freshly computed flags and the
// post-retire pending state combinationally in the load cycle. When it is not
// defined, flags and pending are driven only from registers.
`ifndef WORDSIZE
`define WORDSIZE 64
`endif
`ifndef FLAGSIZE
`define FLAGSIZE 4
`endif

module flag_unit #(
  parameter int MAXPENDING = 3  // 1..7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue,
  input  logic                 wr,
  input  logic                 setflags,
  input  logic [1:0]           op,
  input  logic [`WORDSIZE-1:0] a,
  input  logic [`WORDSIZE-1:0] b,
  input  logic [`WORDSIZE-1:0] result,
  output logic [`FLAGSIZE-1:0] flags,
  output logic                 pending,
  output logic                 full,
  output logic                 err
);

  localparam int             MSB   = `WORDSIZE - 1;
  localparam int             CW    = $clog2(MAXPENDING + 1);
  localparam logic [CW-1:0]  MAXCNT = CW'(MAXPENDING);

  logic [`FLAGSIZE-1:0] r_flags;
  logic [CW-1:0]        r_cnt;
  logic                 r_err;

  logic                 w_retire;
  logic                 w_load;
  logic [`FLAGSIZE-1:0] w_new_flags;
  logic [CW-1:0]        w_cnt_nxt;
  logic                 w_err_set;

  // Every flag-setting writeback retires a setter. The reserved opcode
  // retires too, but it never loads the flag register.
  assign w_retire = wr & setflags;
  assign w_load   = w_retire & (op != 2'b11);

  // Flag computation. Both carries are expressed as magnitude compares:
  //   ADD: carry(a+b)     <=> a > ~b
  //   SUB: carry(a+~b+1)  <=> a >= b   (C=1 means no borrow)
  always_comb begin
    w_new_flags    = '0;
    w_new_flags[3] = result[MSB];
    w_new_flags[2] = (result == '0);
    case (op)
      2'b00: begin
        w_new_flags[1] = (a[MSB] == b[MSB]) & (result[MSB] != a[MSB]);
        w_new_flags[0] = (a > ~b);
      end
      2'b01: begin
        w_new_flags[1] = (a[MSB] != b[MSB]) & (result[MSB] != a[MSB]);
        w_new_flags[0] = (a >= b);
      end
      default: begin
        w_new_flags[1] = 1'b0;
        w_new_flags[0] = 1'b0;
      end
    endcase
  end

  // Next pending count plus protocol checks. An issue and a retire in the
  // same cycle cancel out, so overflow and underflow cannot occur then.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_err_set = 1'b0;
    if (issue && !w_retire) begin
      if (r_cnt == MAXCNT) w_err_set = 1'b1;
      else                 w_cnt_nxt = r_cnt + CW'(1);
    end else if (w_retire && !issue) begin
      if (r_cnt == '0) w_err_set = 1'b1;
      else             w_cnt_nxt = r_cnt - CW'(1);
    end
    if (w_retire && (op == 2'b11)) w_err_set = 1'b1;
  end

  // Flag register: loads only on a valid flag-setting writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_flags <= '0;
    else if (w_load) r_flags <= w_new_flags;
  end

  // Pending counter and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_err_set) r_err <= 1'b1;
    end
  end

`ifdef FLAGBYPASS_EN
  // Forward the load value, and release the stall when the last setter retires.
  assign flags   = w_load ? w_new_flags : r_flags;
  assign pending = (r_cnt > CW'(w_retire));
`else
  assign flags   = r_flags;
  assign pending = (r_cnt != '0);
`endif
  assign full = (r_cnt == MAXCNT);
  assign err  = r_err;

endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: directed bench for flag_unit in its default build (no bypass).
// Expected flags come from a behavioural reference and go into a scoreboard
// queue when each step is driven. They are popped and compared after the edge.
module tb_flag_unit;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst, issue, wr, setflags;
  logic [1:0]   op;
  logic [W-1:0] a, b, result;
  logic [3:0]   flags;
  logic         pending, full, err;

  int         n_asserts = 0;
  int         n_fail    = 0;
  logic [3:0] sb[$];
  int         m_cnt;
  logic       m_err;
  logic [3:0] m_flags;

  flag_unit #(.MAXPENDING(3)) dut (
    .clk(clk), .rst(rst), .issue(issue), .wr(wr), .setflags(setflags),
    .op(op), .a(a), .b(b), .result(result),
    .flags(flags), .pending(pending), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  // Reference flags: carries from widened sums, overflow from signed signs.
  function automatic logic [3:0] ref_flags(input logic [1:0] o,
                                           input logic [W-1:0] x, y, r);
    logic n, z, v, c;
    n = r[W-1];
    z = (r == '0);
    v = 1'b0;
    c = 1'b0;
    case (o)
      2'd0: begin
        c = ((({1'b0, x} + {1'b0, y}) >> W) != '0);
        v = ($signed(x) >= 0 && $signed(y) >= 0 && $signed(r) < 0) ||
            ($signed(x) < 0  && $signed(y) < 0  && $signed(r) >= 0);
      end
      2'd1: begin
        c = ((({1'b0, x} + {1'b0, ~y} + 65'd1) >> W) != '0);
        v = ($signed(x) >= 0 && $signed(y) < 0  && $signed(r) < 0) ||
            ($signed(x) < 0  && $signed(y) >= 0 && $signed(r) >= 0);
      end
      default: ;
    endcase
    return {n, z, v, c};
  endfunction

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".flags"},   flags,   sb.pop_front());
    chk({tag, ".pending"}, {3'b0, pending}, {3'b0, m_cnt != 0});
    chk({tag, ".full"},    {3'b0, full},    {3'b0, m_cnt == 3});
    chk({tag, ".err"},     {3'b0, err},     {3'b0, m_err});
  endtask

  // One clock of stimulus: drive at negedge, update the model, check after posedge.
  task automatic step(input string tag, input logic i_iss, i_wr, i_sf,
                      input logic [1:0] i_op, input logic [W-1:0] i_a, i_b);
    logic [W-1:0] r;
    logic         ret;
    case (i_op)
      2'd0:    r = i_a + i_b;
      2'd1:    r = i_a - i_b;
      2'd2:    r = i_a & i_b;
      default: r = i_a | i_b;
    endcase
    @(negedge clk);
    issue = i_iss; wr = i_wr; setflags = i_sf; op = i_op;
    a = i_a; b = i_b; result = r;
    ret = i_wr & i_sf;
    if (ret && i_op != 2'd3) m_flags = ref_flags(i_op, i_a, i_b, r);
    if (ret && i_op == 2'd3) m_err = 1'b1;
    if (i_iss && !ret) begin
      if (m_cnt == 3) m_err = 1'b1; else m_cnt++;
    end else if (ret && !i_iss) begin
      if (m_cnt == 0) m_err = 1'b1; else m_cnt--;
    end
    sb.push_back(m_flags);
    @(posedge clk);
    #1;
    chk_state(tag);
    issue = 0; wr = 0; setflags = 0; op = 0;
  endtask

  // Asynchronous reset pulse in mid-cycle, checked before the next edge.
  task automatic reset_mid(input string tag);
    @(negedge clk);
    #1 rst = 1'b1;
    m_cnt = 0; m_err = 1'b0; m_flags = 4'b0;
    sb.delete();
    #1;
    sb.push_back(m_flags);
    chk_state(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; issue = 0; wr = 0; setflags = 0; op = 0;
    a = '0; b = '0; result = '0;
    m_cnt = 0; m_err = 1'b0; m_flags = 4'b0;
    #12;
    sb.push_back(4'b0);
    chk_state("reset");
    rst = 1'b0;

    // Flag computation, each setter issued and then retired.
    step("iss0", 1, 0, 0, 2'd0, '0, '0);
    step("add_ovf", 0, 1, 1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    chk("add_ovf_const", flags, 4'b1010);
    step("iss1", 1, 0, 0, 2'd0, '0, '0);
    step("sub_eq", 0, 1, 1, 2'd1, 64'd5, 64'd5);
    chk("sub_eq_const", flags, 4'b0101);
    step("iss2", 1, 0, 0, 2'd0, '0, '0);
    step("sub_borrow", 0, 1, 1, 2'd1, 64'd0, 64'd1);
    chk("sub_borrow_const", flags, 4'b1000);
    step("iss3", 1, 0, 0, 2'd0, '0, '0);
    step("add_wrap", 0, 1, 1, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    step("iss4", 1, 0, 0, 2'd0, '0, '0);
    step("and", 0, 1, 1, 2'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
    step("iss5", 1, 0, 0, 2'd0, '0, '0);
    step("sub_neg_ovf", 0, 1, 1, 2'd1, 64'h8000_0000_0000_0000, 64'd1);

    // Half-asserted writebacks leave the flags alone.
    step("wr_only", 0, 1, 0, 2'd0, 64'd3, 64'd4);
    step("sf_only", 0, 0, 1, 2'd1, 64'd3, 64'd4);
    chk("no_err_yet", {3'b0, err}, 4'b0);

    // Fill to MAXPENDING, overflow once, then drain.
    step("fill1", 1, 0, 0, 2'd0, '0, '0);
    step("fill2", 1, 0, 0, 2'd0, '0, '0);
    step("fill3", 1, 0, 0, 2'd0, '0, '0);
    chk("full_at3", {3'b0, full}, 4'b1);
    step("fill4", 1, 0, 0, 2'd0, '0, '0);
    chk("ovf_err", {3'b0, err}, 4'b1);
    step("drain1", 0, 1, 1, 2'd0, 64'd1, 64'd2);
    step("drain2", 0, 1, 1, 2'd2, 64'd6, 64'd3);
    step("drain3", 0, 1, 1, 2'd1, 64'd9, 64'd4);
    chk("drained", {3'b0, pending}, 4'b0);

    // Build up state, then reset asynchronously in mid-cycle.
    step("pre_rst_a", 1, 0, 0, 2'd0, '0, '0);
    step("pre_rst_b", 1, 0, 0, 2'd0, '0, '0);
    step("pre_rst_c", 1, 1, 1, 2'd1, 64'd0, 64'd7);
    reset_mid("rst_mid");

    // Issue and retire in the same cycle at count 1.
    step("post_iss", 1, 0, 0, 2'd0, '0, '0);
    step("iss_ret", 1, 1, 1, 2'd0, 64'd10, 64'd20);
    chk("iss_ret_pend", {3'b0, pending}, 4'b1);
    step("ret_last", 0, 1, 1, 2'd1, 64'd3, 64'd9);
    step("ret_underflow", 0, 1, 1, 2'd2, 64'd0, 64'd5);
    chk("udf_err", {3'b0, err}, 4'b1);

    // Reserved opcode: retires, keeps flags, sets err.
    reset_mid("rst_mid2");
    step("iss_r", 1, 0, 0, 2'd0, '0, '0);
    step("pre_res", 1, 1, 1, 2'd1, 64'd2, 64'd9);
    step("op_res", 0, 1, 1, 2'd3, 64'd0, 64'd0);
    chk("op_res_err", {3'b0, err}, 4'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
